// File: rtl/lsu_pkg.sv
// Shared LSU definitions: state encoding, byte-lane mask and alignment helpers.
// Supplies the core's `Wdt* width encodings if they are not already defined.
`ifndef WdtTypeCnt
`define WdtTypeCnt 2
`define Wdt8  2'd0
`define Wdt16 2'd1
`define Wdt32 2'd2
`define Wdt64 2'd3
`endif

package lsu_pkg;

  localparam int unsigned BYTE_LANES = 8;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } state_t;

  typedef logic [`WdtTypeCnt-1:0] wdt_t;

  function automatic logic [BYTE_LANES-1:0] base_mask(input wdt_t wdt);
    logic [BYTE_LANES-1:0] m;
    case (wdt)
      `Wdt8:   m = 8'h01;
      `Wdt16:  m = 8'h03;
      `Wdt32:  m = 8'h0f;
      default: m = 8'hff;
    endcase
    return m;
  endfunction

  function automatic logic misaligned(input wdt_t wdt, input logic [2:0] offset);
    logic bad;
    case (wdt)
      `Wdt16:  bad = offset[0];
      `Wdt32:  bad = |offset[1:0];
      `Wdt64:  bad = |offset;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store data shift and byte mask, load shift and
// sign/zero extension to the full data width.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_W = 64
) (
  input  logic [2:0]            offset,
  input  wdt_t                  wdt,
  input  logic                  is_unsigned,
  input  logic [DATA_W-1:0]     st_data,
  output logic [DATA_W-1:0]     st_shifted,
  output logic [BYTE_LANES-1:0] st_mask,
  input  logic [DATA_W-1:0]     ld_raw,
  output logic [DATA_W-1:0]     ld_data
);

  logic [5:0]        bit_shift;
  logic [DATA_W-1:0] ld_shifted;

  assign bit_shift = {offset, 3'b000};

  always_comb begin
    st_shifted = st_data << bit_shift;
    st_mask    = base_mask(wdt) << offset;
    ld_shifted = ld_raw >> bit_shift;
    ld_data    = ld_shifted;
    case (wdt)
      `Wdt8:   ld_data = {{(DATA_W-8){~is_unsigned & ld_shifted[7]}}, ld_shifted[7:0]};
      `Wdt16:  ld_data = {{(DATA_W-16){~is_unsigned & ld_shifted[15]}}, ld_shifted[15:0]};
      `Wdt32:  ld_data = {{(DATA_W-32){~is_unsigned & ld_shifted[31]}}, ld_shifted[31:0]};
      default: ld_data = ld_shifted;
    endcase
  end

endmodule

// File: rtl/lsu_master.sv
// Single-outstanding load/store initiator between the core and data memory.
// Optional watchdog in REQ/WAIT is built only when LSU_TIMEOUT_EN is defined.
module lsu_master
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W         = 64,
  parameter int unsigned DATA_W         = 64,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [`WdtTypeCnt-1:0] req_wdt,
  input  logic                  req_unsigned,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_misalign,
  output logic                  resp_timeout,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_wen,
  output logic [ADDR_W-1:0]     mem_req_addr,
  output logic [DATA_W-1:0]     mem_req_wdata,
  output logic [BYTE_LANES-1:0] mem_req_wmask,
  input  logic                  mem_resp_valid,
  input  logic [DATA_W-1:0]     mem_resp_rdata
);

  state_t            state_q, state_d;
  logic              wen_q, unsigned_q, misalign_q, timeout_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  wdt_t              wdt_q;
  logic              accept, capture_rdata, timeout_hit;
  logic              in_req, in_resp;
  logic [DATA_W-1:0] st_shifted, ld_data;
  logic [BYTE_LANES-1:0] st_mask;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CNT_W =
    ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [CNT_W-1:0] cnt_q;
  logic             timeout_fire;

  // Counter value k is visible in the k-th cycle after REQ entry; firing on
  // CNT_LAST makes RESP land exactly TIMEOUT_CYCLES cycles after entry.
  assign timeout_hit  = (cnt_q >= CNT_LAST);
  assign timeout_fire = timeout_hit &&
                        ((state_q == REQ && !mem_req_ready) ||
                         (state_q == WAIT && !mem_resp_valid));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (accept) begin
        cnt_q <= '0;
      end else if (state_q == REQ || state_q == WAIT) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (accept) begin
        timeout_q <= 1'b0;
      end else if (timeout_fire) begin
        timeout_q <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_q   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wen_q      <= 1'b0;
      unsigned_q <= 1'b0;
      misalign_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wdt_q      <= '0;
      rdata_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        wen_q      <= req_wen;
        unsigned_q <= req_unsigned;
        misalign_q <= misaligned(req_wdt, req_addr[2:0]);
        addr_q     <= req_addr;
        wdata_q    <= req_wdata;
        wdt_q      <= req_wdt;
      end
      if (capture_rdata) begin
        rdata_q <= mem_resp_rdata;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    capture_rdata = 1'b0;
    req_ready     = 1'b0;
    mem_req_valid = 1'b0;
    resp_valid    = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept  = 1'b1;
          state_d = misaligned(req_wdt, req_addr[2:0]) ? RESP : REQ;
        end
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          state_d = WAIT;
        end else if (timeout_hit) begin
          state_d = RESP;
        end
      end
      WAIT: begin
        if (mem_resp_valid) begin
          capture_rdata = 1'b1;
          state_d       = RESP;
        end else if (timeout_hit) begin
          state_d = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  lsu_align #(
    .DATA_W(DATA_W)
  ) u_align (
    .offset      (addr_q[2:0]),
    .wdt         (wdt_q),
    .is_unsigned (unsigned_q),
    .st_data     (wdata_q),
    .st_shifted  (st_shifted),
    .st_mask     (st_mask),
    .ld_raw      (rdata_q),
    .ld_data     (ld_data)
  );

  assign in_req  = (state_q == REQ);
  assign in_resp = (state_q == RESP);

  assign mem_req_wen   = in_req & wen_q;
  assign mem_req_addr  = in_req ? {addr_q[ADDR_W-1:3], 3'b000} : '0;
  assign mem_req_wdata = in_req ? st_shifted : '0;
  assign mem_req_wmask = (in_req & wen_q) ? st_mask : '0;

  assign resp_misalign = in_resp & misalign_q;
  assign resp_timeout  = in_resp & timeout_q;
  assign resp_rdata    = (in_resp & ~wen_q & ~misalign_q & ~timeout_q) ? ld_data : '0;

endmodule

// File: tb/tb_lsu_master.sv
// Bench for lsu_master: directed scenarios plus randomized transactions checked
// against an arithmetic reference model of lane steering and latency.
`timescale 1ns/1ps
`ifndef WdtTypeCnt
`define WdtTypeCnt 2
`define Wdt8  2'd0
`define Wdt16 2'd1
`define Wdt32 2'd2
`define Wdt64 2'd3
`endif

module tb_lsu_master;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int TMO    = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_wen = 1'b0, req_unsigned = 1'b0;
  logic [63:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  req_wdt = '0;
  logic        resp_valid, resp_misalign, resp_timeout;
  logic [63:0] resp_rdata;
  logic        mem_req_valid, mem_req_ready = 1'b0, mem_req_wen;
  logic [63:0] mem_req_addr, mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_resp_valid = 1'b0;
  logic [63:0] mem_resp_rdata = '0;

  lsu_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wdt(req_wdt),
    .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_misalign(resp_misalign), .resp_timeout(resp_timeout),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_wen(mem_req_wen), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic        obs_acc_ready, obs_wen, obs_misalign, obs_timeout, obs_ready_after, obs_extra;
  logic [63:0] obs_addr, obs_wdata, obs_rdata;
  logic [7:0]  obs_wmask;
  int          obs_mem_cycles, obs_unstable, obs_resp_cycle;

  // Reference model: access size in bytes is 1 << wdt.
  function automatic bit m_misal(input logic [1:0] wdt, input logic [63:0] a);
    int sz = 1 << wdt;
    return (a % 64'(sz)) != 0;
  endfunction

  function automatic logic [63:0] m_load(input logic [1:0] wdt, input logic [63:0] a,
                                         input logic uns, input logic [63:0] d);
    int sz = 1 << wdt;
    logic [127:0] v, lim;
    v   = {64'b0, d} >> (8 * (a % 8));
    lim = (128'd1 << (8 * sz)) - 128'd1;
    v   = v & lim;
    if (!uns && v[8*sz-1]) v = v | ~lim;
    return v[63:0];
  endfunction

  function automatic logic [7:0] m_mask(input logic [1:0] wdt, input logic [63:0] a);
    int m = ((1 << (1 << wdt)) - 1) << (a % 8);
    return m[7:0];
  endfunction

  function automatic logic [63:0] m_wdata(input logic [63:0] a, input logic [63:0] d);
    return d << (8 * (a % 8));
  endfunction

  // Drives one request and plays the memory slave; records what it observes.
  task automatic run_txn(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [1:0] wdt, input logic uns, input logic [63:0] mem_data,
                         input int stall, input int delay, input bit respond);
    int cyc, stall_left, delay_left;
    bit in_wait, got, hs, was_req;
    obs_mem_cycles = 0; obs_unstable = 0; obs_resp_cycle = -1; obs_extra = 1'b0;
    obs_addr = '0; obs_wdata = '0; obs_wmask = '0; obs_wen = 1'b0;
    obs_rdata = '0; obs_misalign = 1'b0; obs_timeout = 1'b0; obs_ready_after = 1'b0;
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata;
    req_wdt = wdt; req_unsigned = uns;
    obs_acc_ready = req_ready;
    @(posedge clk); #1;
    req_valid = 1'($urandom_range(0, 1));
    req_wen = 1'($urandom_range(0, 1));
    req_addr = {$urandom, $urandom};
    req_wdata = {$urandom, $urandom};
    cyc = 1; stall_left = stall; delay_left = delay; in_wait = 0; got = 0;
    while (!got && cyc < 400) begin
      mem_resp_valid = 1'b0;
      mem_resp_rdata = {$urandom, $urandom};
      if (in_wait && respond) begin
        if (delay_left == 0) begin
          mem_resp_valid = 1'b1; mem_resp_rdata = mem_data; in_wait = 0;
        end else begin
          delay_left--;
        end
      end
      mem_req_ready = mem_req_valid && (stall_left == 0);
      if (mem_req_valid) begin
        if (obs_mem_cycles == 0) begin
          obs_addr = mem_req_addr; obs_wdata = mem_req_wdata;
          obs_wmask = mem_req_wmask; obs_wen = mem_req_wen;
        end else if (mem_req_addr !== obs_addr || mem_req_wdata !== obs_wdata ||
                     mem_req_wmask !== obs_wmask || mem_req_wen !== obs_wen) begin
          obs_unstable++;
        end
        obs_mem_cycles++;
      end
      if (resp_valid) begin
        got = 1; obs_resp_cycle = cyc; obs_rdata = resp_rdata;
        obs_misalign = resp_misalign; obs_timeout = resp_timeout;
        req_valid = 1'b0;
      end
      hs = mem_req_valid && mem_req_ready;
      was_req = mem_req_valid;
      @(posedge clk); #1;
      if (hs) in_wait = 1;
      else if (was_req && stall_left > 0) stall_left--;
      cyc++;
    end
    mem_resp_valid = 1'b0; mem_req_ready = 1'b0; req_valid = 1'b0;
    obs_extra = resp_valid;
    obs_ready_after = req_ready;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
    vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    vectors++; if (mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL reset_mem_valid: got %b expected 0", mem_req_valid); end
    vectors++; if ({mem_req_addr, mem_req_wdata, mem_req_wmask, mem_req_wen} !== '0) begin miscompares++; $display("FAIL reset_mem_fields: got %h %h %h expected 0", mem_req_addr, mem_req_wdata, mem_req_wmask); end
    vectors++; if ({resp_rdata, resp_misalign, resp_timeout} !== '0) begin miscompares++; $display("FAIL reset_resp_fields: got %h %b %b expected 0", resp_rdata, resp_misalign, resp_timeout); end
    rst_n = 1'b1;
    mem_resp_valid = 1'b1; mem_resp_rdata = 64'hDEAD_BEEF_0000_0001;
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    vectors++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin miscompares++; $display("FAIL idle_stray_resp: got valid=%b ready=%b expected 0/1", resp_valid, req_ready); end
  endtask

  task automatic test_load_byte();
    run_txn(1'b0, 64'h8000_0005, 64'h55, `Wdt8, 1'b0, 64'h0000_8000_0000_0000, 0, 0, 1);
    vectors++; if (obs_acc_ready !== 1'b1) begin miscompares++; $display("FAIL lb_accept: got %b expected 1", obs_acc_ready); end
    vectors++; if (obs_addr !== 64'h8000_0000) begin miscompares++; $display("FAIL lb_mem_addr: got %h expected 0000000080000000", obs_addr); end
    vectors++; if (obs_wen !== 1'b0 || obs_wmask !== 8'h00) begin miscompares++; $display("FAIL lb_load_req: got wen=%b mask=%h expected 0/00", obs_wen, obs_wmask); end
    vectors++; if (obs_resp_cycle !== 3) begin miscompares++; $display("FAIL lb_latency: got %0d expected 3", obs_resp_cycle); end
    vectors++; if (obs_rdata !== 64'hFFFF_FFFF_FFFF_FF80) begin miscompares++; $display("FAIL lb_rdata: got %h expected ffffffffffffff80", obs_rdata); end
    vectors++; if (obs_extra !== 1'b0 || obs_ready_after !== 1'b1) begin miscompares++; $display("FAIL lb_pulse: got extra=%b ready=%b expected 0/1", obs_extra, obs_ready_after); end
  endtask

  task automatic test_store_half();
    run_txn(1'b1, 64'h8000_0006, 64'h1234, `Wdt16, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 1);
    vectors++; if (obs_wdata !== 64'h1234_0000_0000_0000) begin miscompares++; $display("FAIL sh_wdata: got %h expected 1234000000000000", obs_wdata); end
    vectors++; if (obs_wmask !== 8'hC0) begin miscompares++; $display("FAIL sh_wmask: got %h expected c0", obs_wmask); end
    vectors++; if (obs_wen !== 1'b1) begin miscompares++; $display("FAIL sh_wen: got %b expected 1", obs_wen); end
    vectors++; if (obs_resp_cycle !== 3) begin miscompares++; $display("FAIL sh_latency: got %0d expected 3", obs_resp_cycle); end
    vectors++; if (obs_rdata !== 64'h0) begin miscompares++; $display("FAIL sh_rdata: got %h expected 0", obs_rdata); end
  endtask

  task automatic test_misalign();
    run_txn(1'b0, 64'h8000_0002, 64'h0, `Wdt32, 1'b0, 64'h1111_2222_3333_4444, 0, 0, 1);
    vectors++; if (obs_mem_cycles !== 0) begin miscompares++; $display("FAIL mis_no_mem: got %0d cycles expected 0", obs_mem_cycles); end
    vectors++; if (obs_resp_cycle !== 1) begin miscompares++; $display("FAIL mis_latency: got %0d expected 1", obs_resp_cycle); end
    vectors++; if (obs_misalign !== 1'b1 || obs_rdata !== 64'h0) begin miscompares++; $display("FAIL mis_flags: got mis=%b rdata=%h expected 1/0", obs_misalign, obs_rdata); end
    vectors++; if (obs_ready_after !== 1'b1) begin miscompares++; $display("FAIL mis_ready: got %b expected 1", obs_ready_after); end
  endtask

  task automatic test_stall();
    logic [63:0] d;
    d = {$urandom, $urandom};
    run_txn(1'b0, 64'h8000_0100, 64'h0, `Wdt64, 1'b0, d, 5, 3, 1);
    vectors++; if (obs_mem_cycles !== 6) begin miscompares++; $display("FAIL stall_req_cycles: got %0d expected 6", obs_mem_cycles); end
    vectors++; if (obs_unstable !== 0) begin miscompares++; $display("FAIL stall_stable: got %0d changes expected 0", obs_unstable); end
    vectors++; if (obs_resp_cycle !== 11) begin miscompares++; $display("FAIL stall_latency: got %0d expected 11", obs_resp_cycle); end
    vectors++; if (obs_rdata !== d || obs_extra !== 1'b0) begin miscompares++; $display("FAIL stall_rdata: got %h extra=%b expected %h/0", obs_rdata, obs_extra, d); end
`ifndef LSU_TIMEOUT_EN
    run_txn(1'b0, 64'h8000_0200, 64'h0, `Wdt64, 1'b0, d, 0, 40, 1);
    vectors++; if (obs_resp_cycle !== 43 || obs_timeout !== 1'b0) begin miscompares++; $display("FAIL long_wait: got cycle=%0d tmo=%b expected 43/0", obs_resp_cycle, obs_timeout); end
`endif
  endtask

  task automatic test_reset_mid();
    int seen;
    logic [63:0] d;
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 64'h8000_0010; req_wdt = `Wdt64; req_unsigned = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0; mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    vectors++; if (req_ready !== 1'b1 || mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_async: got ready=%b memv=%b expected 1/0", req_ready, mem_req_valid); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_resp_valid = 1'b1; mem_resp_rdata = 64'hCAFE_F00D_1234_5678;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      mem_resp_valid = 1'b0;
      if (resp_valid) seen++;
    end
    vectors++; if (seen !== 0 || req_ready !== 1'b1) begin miscompares++; $display("FAIL rstmid_no_resp: got pulses=%0d ready=%b expected 0/1", seen, req_ready); end
    d = 64'h8765_4321_0FED_CBA9;
    run_txn(1'b0, 64'h8000_0024, 64'h0, `Wdt32, 1'b1, d, 0, 0, 1);
    vectors++; if (obs_rdata !== 64'h0000_0000_8765_4321 || obs_resp_cycle !== 3) begin miscompares++; $display("FAIL rstmid_next: got %h cyc=%0d expected 0000000087654321/3", obs_rdata, obs_resp_cycle); end
  endtask

  task automatic test_random();
    logic wen, uns, mis;
    logic [1:0] wdt;
    logic [63:0] a, wd, md, exp_rd;
    int st, dl, exp_cyc;
    for (int n = 0; n < 40; n++) begin
      wen = 1'($urandom_range(0, 1)); uns = 1'($urandom_range(0, 1));
      wdt = 2'($urandom_range(0, 3));
      a = {$urandom, $urandom}; wd = {$urandom, $urandom}; md = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) a = a - (a % 64'(1 << wdt));
      st = $urandom_range(0, 3); dl = $urandom_range(0, 3);
      mis = m_misal(wdt, a);
      exp_rd = (wen || mis) ? 64'h0 : m_load(wdt, a, uns, md);
      exp_cyc = mis ? 1 : 3 + st + dl;
      run_txn(wen, a, wd, wdt, uns, md, st, dl, 1);
      vectors++; if (obs_acc_ready !== 1'b1 || obs_ready_after !== 1'b1) begin miscompares++; $display("FAIL rnd_ready[%0d]: got %b/%b expected 1/1", n, obs_acc_ready, obs_ready_after); end
      vectors++; if (obs_resp_cycle !== exp_cyc || obs_extra !== 1'b0) begin miscompares++; $display("FAIL rnd_latency[%0d]: got %0d extra=%b expected %0d/0", n, obs_resp_cycle, obs_extra, exp_cyc); end
      vectors++; if (obs_misalign !== mis || obs_timeout !== 1'b0) begin miscompares++; $display("FAIL rnd_flags[%0d]: got mis=%b tmo=%b expected %b/0", n, obs_misalign, obs_timeout, mis); end
      vectors++; if (obs_rdata !== exp_rd) begin miscompares++; $display("FAIL rnd_rdata[%0d]: got %h expected %h", n, obs_rdata, exp_rd); end
      vectors++; if (obs_mem_cycles !== (mis ? 0 : st + 1) || obs_unstable !== 0) begin miscompares++; $display("FAIL rnd_req_cycles[%0d]: got %0d unstable=%0d expected %0d/0", n, obs_mem_cycles, obs_unstable, mis ? 0 : st + 1); end
      if (!mis) begin
        vectors++; if (obs_addr !== (a - (a % 8)) || obs_wen !== wen) begin miscompares++; $display("FAIL rnd_addr[%0d]: got %h wen=%b expected %h/%b", n, obs_addr, obs_wen, a - (a % 8), wen); end
        vectors++; if (obs_wdata !== m_wdata(a, wd)) begin miscompares++; $display("FAIL rnd_wdata[%0d]: got %h expected %h", n, obs_wdata, m_wdata(a, wd)); end
        vectors++; if (obs_wmask !== (wen ? m_mask(wdt, a) : 8'h00)) begin miscompares++; $display("FAIL rnd_wmask[%0d]: got %h expected %h", n, obs_wmask, wen ? m_mask(wdt, a) : 8'h00); end
      end
    end
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout();
    logic [63:0] d;
    run_txn(1'b0, 64'h8000_0300, 64'h0, `Wdt64, 1'b0, 64'h0, 0, 0, 0);
    vectors++; if (obs_resp_cycle !== 1 + TMO || obs_timeout !== 1'b1 || obs_rdata !== 64'h0) begin miscompares++; $display("FAIL tmo_wait: got cyc=%0d tmo=%b rdata=%h expected %0d/1/0", obs_resp_cycle, obs_timeout, obs_rdata, 1 + TMO); end
    run_txn(1'b1, 64'h8000_0308, 64'h1, `Wdt64, 1'b0, 64'h0, 1000, 0, 0);
    vectors++; if (obs_resp_cycle !== 1 + TMO || obs_timeout !== 1'b1) begin miscompares++; $display("FAIL tmo_req: got cyc=%0d tmo=%b expected %0d/1", obs_resp_cycle, obs_timeout, 1 + TMO); end
    d = {$urandom, $urandom};
    run_txn(1'b0, 64'h8000_0310, 64'h0, `Wdt64, 1'b0, d, 0, TMO - 2, 1);
    vectors++; if (obs_resp_cycle !== 1 + TMO || obs_timeout !== 1'b0 || obs_rdata !== d) begin miscompares++; $display("FAIL tmo_resp_wins: got cyc=%0d tmo=%b rdata=%h expected %0d/0/%h", obs_resp_cycle, obs_timeout, obs_rdata, 1 + TMO, d); end
    vectors++; if (obs_ready_after !== 1'b1) begin miscompares++; $display("FAIL tmo_ready: got %b expected 1", obs_ready_after); end
  endtask
`endif

  initial begin
    test_reset();
    test_load_byte();
    test_store_half();
    test_misalign();
    test_stall();
    test_reset_mid();
    test_random();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", vectors);
    $fatal(1, "watchdog expired");
  end

endmodule
